tick_timer_ctrl: RTL

Multi-channel programmable timer controller driven by the one-cycle tick pulse from the project clock divider.
- Shares that single tick source among NUM_CH independent channels.
- Each channel counts a configured number of ticks, then emits a one-cycle expire pulse, either one-shot or auto-reloading.
- Sits between the divider and consumers such as display refresh, debounce and LED blink logic. Consumers start, stop and reprogram channels through a simple write/command interface.

---
 rtl/tick_timer_pkg.sv | 26 ++
 rtl/tick_timer_channel.sv | 85 ++++++++
 rtl/tick_timer_ctrl.sv | 60 ++++++
 3 files changed

// File: rtl/tick_timer_pkg.sv
// Shared types for the tick timer: channel state encoding, default widths
// and the per-channel command priority (stop > start > tick).
package tick_timer_pkg;

    localparam int CNT_WIDTH_DEF = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_TICK  = 2'd1,
        CMD_START = 2'd2,
        CMD_STOP  = 2'd3
    } cmd_t;

    function automatic cmd_t cmd_decode(input logic stop, input logic start, input logic tick);
        if (stop)       return CMD_STOP;
        else if (start) return CMD_START;
        else if (tick)  return CMD_TICK;
        else            return CMD_NONE;
    endfunction

endpackage

// File: rtl/tick_timer_channel.sv
// One timer channel: period/mode registers, IDLE/RUN FSM, tick down-counter
// and a registered one-cycle expire pulse.
module tick_timer_channel
    import tick_timer_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 cfg_we,
    input  logic [CNT_WIDTH-1:0] cfg_period,
    input  logic                 cfg_oneshot,
    input  logic                 start,
    input  logic                 stop,
    output logic                 expire,
    output logic                 running,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] period;
    logic                 oneshot;
    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] count_nxt;
    logic                 expire_nxt;

    // Config write lands next cycle, so a same-cycle reload sees the old period.
    always_ff @(posedge clk) begin
        if (rst) begin
            period  <= '0;
            oneshot <= 1'b0;
            state   <= ST_IDLE;
            count   <= '0;
            expire  <= 1'b0;
        end else begin
            if (cfg_we) begin
                period  <= cfg_period;
                oneshot <= cfg_oneshot;
            end
            state  <= state_nxt;
            count  <= count_nxt;
            expire <= expire_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        expire_nxt = 1'b0;
        unique case (cmd_decode(stop, start, tick))
            CMD_STOP: begin
                if (state == ST_RUN) begin
                    state_nxt = ST_IDLE;
                    count_nxt = '0;
                end
            end
            CMD_START: begin
                if (period != '0) begin
                    state_nxt = ST_RUN;
                    count_nxt = period;
                end
            end
            CMD_TICK: begin
                if (state == ST_RUN) begin
                    if (count > CNT_WIDTH'(1)) begin
                        count_nxt = count - CNT_WIDTH'(1);
                    end else begin
                        expire_nxt = 1'b1;
                        // A period cleared mid-run cannot reload, so it retires like one-shot.
                        if (oneshot || period == '0) begin
                            state_nxt = ST_IDLE;
                            count_nxt = '0;
                        end else begin
                            count_nxt = period;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    assign running = (state == ST_RUN);

endmodule

// File: rtl/tick_timer_ctrl.sv
// Multi-channel tick timer: fans the divider tick out to NUM_CH channels,
// decodes config writes and provides a registered count readback port.
module tick_timer_ctrl
    import tick_timer_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int CH_W      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 cfg_we,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [CNT_WIDTH-1:0] cfg_period,
    input  logic                 cfg_oneshot,
    input  logic [NUM_CH-1:0]    start,
    input  logic [NUM_CH-1:0]    stop,
    input  logic [CH_W-1:0]      rd_ch,
    output logic [NUM_CH-1:0]    expire,
    output logic [NUM_CH-1:0]    running,
    output logic [CNT_WIDTH-1:0] rd_count
);

    logic [NUM_CH-1:0]                ch_we;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0] counts;
    logic [CNT_WIDTH-1:0]             rd_nxt;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        // Indices at or above NUM_CH never match, so those writes are dropped.
        assign ch_we[g] = cfg_we && (cfg_ch == CH_W'(g));

        tick_timer_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
            .clk         (clk),
            .rst         (rst),
            .tick        (tick),
            .cfg_we      (ch_we[g]),
            .cfg_period  (cfg_period),
            .cfg_oneshot (cfg_oneshot),
            .start       (start[g]),
            .stop        (stop[g]),
            .expire      (expire[g]),
            .running     (running[g]),
            .count       (counts[g])
        );
    end

    always_comb begin
        rd_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CH_W'(i)) rd_nxt = counts[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rd_count <= '0;
        else     rd_count <= rd_nxt;
    end

endmodule
